register_memory_mp: RTL and testbench

Parametrised multi-read-port integer register file with a per-register pending-write scoreboard, the successor to the fixed 32x32 two-port register memory in the core's decode/writeback path. Register 0 is hardwired to zero. Writes land on the rising clock edge. Reads are combinational. A reserve/release scoreboard lets the pipeline mark destination registers busy at issue and clear them at writeback, so hazard logic can stall on `rd_busy`.

---
 rtl/register_memory_mp.sv | 94 +++++++++
 tb/tb_register_memory_mp.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/register_memory_mp.sv
// Multi-read-port register file with a pending-write scoreboard. Reads are combinational, writes and reservations take effect on the edge.
// A reservation of a busy register is refused and the requester holds it. Define REGFILE_BYPASS_EN for same-cycle write forwarding.
module register_memory_mp #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_address,
  output logic [NRD*XLEN-1:0] data_out,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wr_enable,
  input  logic [AW-1:0]       wr_address,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                rsv_enable,
  input  logic [AW-1:0]       rsv_address,
  output logic                rsv_ready,
  output logic [AW:0]         pending_count
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:1] busy_q;
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic [AW:0]      count_nxt;
  logic             wr_hit;
  logic             rsv_hit;
  logic             wr_clears;

  assign busy      = {busy_q, 1'b0};
  assign wr_hit    = wr_enable && (wr_address != '0);
  assign wr_clears = wr_hit && busy[wr_address];

  // A write retiring into the requested register frees it in the same cycle.
  assign rsv_ready = rsv_enable && ((rsv_address == '0) || !busy[rsv_address] ||
                                    (wr_hit && (wr_address == rsv_address)));
  assign rsv_hit   = rsv_ready && (rsv_address != '0);

  always_comb begin
    busy_nxt = busy;
    if (wr_hit)
      busy_nxt[wr_address] = 1'b0;
    // Applied after the clear so a new reservation wins over a retiring write.
    if (rsv_hit)
      busy_nxt[rsv_address] = 1'b1;
  end

  always_comb begin
    count_nxt = pending_count;
    case ({rsv_hit, wr_clears})
      2'b10:   count_nxt = pending_count + 1'b1;
      2'b01:   count_nxt = pending_count - 1'b1;
      default: count_nxt = pending_count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q        <= '0;
      pending_count <= '0;
    end else begin
      busy_q        <= busy_nxt[NREGS-1:1];
      pending_count <= count_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else if (wr_hit) begin
      regs[wr_address] <= wr_data;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] stored;
    assign addr   = rd_address[p*AW +: AW];
    assign stored = (addr == '0) ? '0 : regs[addr];
`ifdef REGFILE_BYPASS_EN
    logic fwd;
    assign fwd                       = wr_hit && (addr == wr_address);
    assign data_out[p*XLEN +: XLEN]  = fwd ? wr_data : stored;
    assign rd_busy[p]                = fwd ? 1'b0 : busy[addr];
`else
    assign data_out[p*XLEN +: XLEN]  = stored;
    assign rd_busy[p]                = busy[addr];
`endif
  end

endmodule

// File: tb/tb_register_memory_mp.sv
// Scoreboard bench for register_memory_mp: directed scenarios, then randomized traffic against an array-based model.
module tb_register_memory_mp;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic [NRD*AW-1:0]   rd_address;
  logic [NRD*XLEN-1:0] data_out;
  logic [NRD-1:0]      rd_busy;
  logic                wr_enable;
  logic [AW-1:0]       wr_address;
  logic [XLEN-1:0]     wr_data;
  logic                rsv_enable;
  logic [AW-1:0]       rsv_address;
  logic                rsv_ready;
  logic [AW:0]         pending_count;

  register_memory_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clk(clk), .rst(rst), .rd_address(rd_address), .data_out(data_out),
    .rd_busy(rd_busy), .wr_enable(wr_enable), .wr_address(wr_address),
    .wr_data(wr_data), .rsv_enable(rsv_enable), .rsv_address(rsv_address),
    .rsv_ready(rsv_ready), .pending_count(pending_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string               name;
    logic [NRD*XLEN-1:0] data;
    logic [NRD-1:0]      busy;
    logic                rdy;
    logic [AW:0]         cnt;
  } exp_t;

  exp_t            q[$];
  logic [XLEN-1:0] mregs [NREGS];
  bit              mbusy [NREGS];
  int              passed = 0;
  int              total  = 0;

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < NREGS; i++) n += int'(mbusy[i]);
    return n;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < NREGS; i++) begin
      mregs[i] = '0;
      mbusy[i] = 1'b0;
    end
  endfunction

  // Expected pre-edge outputs from the model state and the current inputs.
  task automatic push_exp(input string nm, output logic rdy);
    exp_t e;
    int   a;
    bit   wr_real;
    e.name  = nm;
    wr_real = wr_enable && (wr_address != 0);
    for (int i = 0; i < NRD; i++) begin
      a = int'(rd_address[i*AW +: AW]);
      e.data[i*XLEN +: XLEN] = (a == 0) ? '0 : mregs[a];
      e.busy[i]              = mbusy[a];
`ifdef REGFILE_BYPASS_EN
      if (wr_real && a == int'(wr_address)) begin
        e.data[i*XLEN +: XLEN] = wr_data;
        e.busy[i]              = 1'b0;
      end
`endif
    end
    e.rdy = rsv_enable && (rsv_address == 0 || !mbusy[rsv_address] ||
                           (wr_real && wr_address == rsv_address));
    e.cnt = (AW+1)'(model_count());
    rdy   = e.rdy;
    q.push_back(e);
  endtask

  // One clock cycle of stimulus: drive, predict, then advance the model past the edge.
  task automatic step(input string nm, input logic [AW-1:0] r1, input logic [AW-1:0] r0,
                      input logic we, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                      input logic re, input logic [AW-1:0] ra, output logic rdy);
    rd_address  = {r1, r0};
    wr_enable   = we;
    wr_address  = wa;
    wr_data     = wd;
    rsv_enable  = re;
    rsv_address = ra;
    push_exp(nm, rdy);
    if (!rst) begin
      if (we && wa != 0) begin
        mregs[wa] = wd;
        mbusy[wa] = 1'b0;
      end
      if (rdy && ra != 0) mbusy[ra] = 1'b1;
    end
    @(posedge clk);
    #2;
  endtask

  // Reset asserted between edges; outputs must clear before the next edge.
  task automatic do_reset(input string nm, input logic [AW-1:0] r1, input logic [AW-1:0] r0);
    logic rdy;
    rd_address = {r1, r0};
    wr_enable  = 1'b0;
    rsv_enable = 1'b1;
    rsv_address = 5'd9;
    #1;
    rst = 1'b1;
    model_clear();
    push_exp(nm, rdy);
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string nm, input logic [NRD*XLEN-1:0] act, input logic [NRD*XLEN-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({e.name, ".data"}, data_out, e.data);
        chk({e.name, ".busy"}, {{(NRD*XLEN-NRD){1'b0}}, rd_busy}, {{(NRD*XLEN-NRD){1'b0}}, e.busy});
        chk({e.name, ".rdy"},  {{(NRD*XLEN-1){1'b0}}, rsv_ready}, {{(NRD*XLEN-1){1'b0}}, e.rdy});
        chk({e.name, ".cnt"},  {{(NRD*XLEN-AW-1){1'b0}}, pending_count}, {{(NRD*XLEN-AW-1){1'b0}}, e.cnt});
      end
    end
  end

  initial begin : stim
    logic rdy;
    logic prev_re, prev_rdy;
    logic [AW-1:0] prev_ra, ra, wa, r0, r1;
    logic re, we;
    rst = 1'b1;
    rd_address = '0; wr_enable = 1'b0; wr_address = '0; wr_data = '0;
    rsv_enable = 1'b0; rsv_address = '0;
    model_clear();
    @(posedge clk); #2;
    do_reset("rst_0_5", 5'd5, 5'd0);
    // Write and reserve while held in reset must not take effect.
    step("rst_31", 5'd31, 5'd31, 1'b1, 5'd5, 32'h55555555, 1'b1, 5'd5, rdy);
    rst = 1'b0;
    step("rd_after_rst", 5'd5, 5'd31, 1'b0, 5'd0, '0, 1'b0, 5'd0, rdy);

    step("w0_rsv0", 5'd0, 5'd0, 1'b1, 5'd0, 32'hEEEEEEEE, 1'b1, 5'd0, rdy);
    step("rd0", 5'd0, 5'd0, 1'b0, 5'd0, '0, 1'b0, 5'd0, rdy);
    step("rsv10", 5'd10, 5'd10, 1'b0, 5'd0, '0, 1'b1, 5'd10, rdy);
    step("rd10_rsv10_again", 5'd0, 5'd10, 1'b0, 5'd0, '0, 1'b1, 5'd10, rdy);
    step("w10", 5'd10, 5'd10, 1'b1, 5'd10, 32'hABCDEFAB, 1'b0, 5'd0, rdy);
    step("rd10_after_w", 5'd10, 5'd10, 1'b0, 5'd0, '0, 1'b0, 5'd0, rdy);
    step("rsv7", 5'd7, 5'd7, 1'b0, 5'd0, '0, 1'b1, 5'd7, rdy);
    step("w7_rsv7", 5'd7, 5'd7, 1'b1, 5'd7, 32'h12345678, 1'b1, 5'd7, rdy);
    step("rd7", 5'd7, 5'd7, 1'b0, 5'd0, '0, 1'b0, 5'd0, rdy);
    step("w_notbusy", 5'd4, 5'd4, 1'b1, 5'd4, 32'h0BADBEEF, 1'b0, 5'd0, rdy);
    step("w3_rd3", 5'd3, 5'd3, 1'b1, 5'd3, 32'hCAFEF00D, 1'b0, 5'd0, rdy);
    step("rd3_after", 5'd3, 5'd3, 1'b0, 5'd0, '0, 1'b0, 5'd0, rdy);

    // Randomized traffic; refused reservations are held until accepted.
    prev_re = 1'b0; prev_rdy = 1'b0; prev_ra = '0;
    for (int n = 0; n < 600; n++) begin
      r0 = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 31));
      wa = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 31));
      we = ($urandom_range(0, 2) != 0);
      if (prev_re && !prev_rdy) begin
        re = 1'b1;
        ra = prev_ra;
      end else begin
        re = ($urandom_range(0, 1) == 1);
        ra = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 31));
      end
      step("rand", r1, r0, we, wa, $urandom, re, ra, rdy);
      prev_re = re; prev_rdy = rdy; prev_ra = ra;
    end

    do_reset("rst_pre_fill", 5'd1, 5'd2);
    rst = 1'b0;
    for (int i = 1; i < NREGS; i++)
      step("fill", AW'(i), 5'd0, 1'b1, AW'(i), XLEN'(i * 32'h01010101), 1'b1, AW'(i), rdy);
    step("full", 5'd31, 5'd1, 1'b0, 5'd0, '0, 1'b1, 5'd0, rdy);
    do_reset("rst_mid", 5'd31, 5'd17);
    rst = 1'b0;
    step("after_rst", 5'd17, 5'd31, 1'b0, 5'd0, '0, 1'b1, 5'd17, rdy);
    step("after_rst2", 5'd17, 5'd1, 1'b0, 5'd0, '0, 1'b0, 5'd0, rdy);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      total++;
      $display("FAIL drain: got %0d pending expectations expected 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
